// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divisor and vote helpers.
// Used by uart_receiver and, later, by the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks, phase reset by clr.
module uart_baud_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_c
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick_c = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_receiver.sv
// Oversampling 8N1 UART receiver with valid/ready holding register and error pulses.
// Even parity stage is added when UART_RX_PARITY_EN is defined.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk50,
  input  logic                 rst50,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned IW  = $clog2(DATA_BITS);
  localparam int unsigned MID = OVERSAMPLE / 2 - 1;

  state_t               state;
  state_t               state_next;
  logic                 rx_meta;
  logic                 rxs;
  logic                 tick_c;
  logic [SW-1:0]        scnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 v0;
  logic                 v1;
  logic                 vote_c;
  logic                 mid_c;
  logic                 wrap_c;
  logic                 start_c;
  logic                 shift_c;
  logic                 deliver_c;
  logic                 ferr_c;
`ifdef UART_RX_PARITY_EN
  logic                 par_chk_c;
  logic                 perr_c;
  logic                 par_bad;
`endif

  // Two-flop synchronizer, idles high.
  always_ff @(posedge clk50) begin
    if (rst50) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rxs     <= rx_meta;
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk    (clk50),
    .rst    (rst50),
    .clr    (start_c),
    .tick_c (tick_c)
  );

  // Vote resolves on the tick after mid-bit, once all three samples exist.
  assign mid_c  = tick_c && (scnt == SW'(MID + 1));
  assign wrap_c = tick_c && (scnt == SW'(OVERSAMPLE - 1));
  assign vote_c = majority3(v0, v1, rxs);

  always_ff @(posedge clk50) begin
    if (rst50) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (!rxs) state_next = START;
      START: begin
        if (mid_c && vote_c) state_next = IDLE;
        else if (wrap_c)     state_next = DATA;
      end
      DATA: begin
        if (wrap_c && (idx == IW'(DATA_BITS - 1))) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
      PARITY: if (wrap_c) state_next = STOP;
      STOP:   if (mid_c) state_next = vote_c ? IDLE : BREAK;
      BREAK:  if (rxs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start_c   = 1'b0;
    shift_c   = 1'b0;
    deliver_c = 1'b0;
    ferr_c    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_chk_c = 1'b0;
    perr_c    = 1'b0;
`endif
    unique case (state)
      IDLE: start_c = !rxs;
      DATA: shift_c = mid_c;
`ifdef UART_RX_PARITY_EN
      PARITY: par_chk_c = mid_c;
`endif
      STOP: begin
        if (mid_c) begin
          if (!vote_c) ferr_c = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (par_bad) perr_c = 1'b1;
`endif
          else deliver_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Bit timing, majority samples and LSB-first shift register.
  always_ff @(posedge clk50) begin
    if (rst50) begin
      scnt  <= '0;
      idx   <= '0;
      shreg <= '0;
      v0    <= 1'b1;
      v1    <= 1'b1;
    end else begin
      if (start_c) begin
        scnt <= '0;
        idx  <= '0;
      end else begin
        if (tick_c) scnt <= (scnt == SW'(OVERSAMPLE - 1)) ? '0 : scnt + SW'(1);
        if ((state == DATA) && wrap_c) idx <= idx + IW'(1);
      end
      if (tick_c && (scnt == SW'(MID - 1))) v0 <= rxs;
      if (tick_c && (scnt == SW'(MID)))     v1 <= rxs;
      if (shift_c) shreg <= {vote_c, shreg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk50) begin
    if (rst50) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (start_c)        par_bad <= 1'b0;
      else if (par_chk_c) par_bad <= (vote_c != (^shreg));
      parity_err <= perr_c;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // Holding register; a deliver into a full, unconsumed register is an overrun.
  always_ff @(posedge clk50) begin
    if (rst50) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy      <= (state_next != IDLE);
      frame_err <= ferr_c;
      overrun   <= 1'b0;
      if (deliver_c && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else begin
        if (rx_valid && rx_ready) rx_valid <= 1'b0;
        if (deliver_c)            overrun  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: vector table of frames plus hand sequences
// for glitch, overrun, coincident consume, mid-frame reset and (UART_RX_PARITY_EN) parity.
`timescale 1ns/1ps
module tb_uart_receiver;
  localparam int BIT_CLKS = 16 * 27;

  logic       clk50;
  logic       rst50;
  logic       uart_rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int         n_acc  = 0;
  int         n_ferr = 0;
  int         n_perr = 0;
  int         n_ovr  = 0;
  logic [7:0] last_acc = 8'h00;

  uart_receiver dut (
    .clk50      (clk50),
    .rst50      (rst50),
    .uart_rxd   (uart_rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  // Event counters sampled mid-cycle.
  always @(negedge clk50) begin
    if (rx_valid && rx_ready) begin
      n_acc    <= n_acc + 1;
      last_acc <= rx_data;
    end
    if (frame_err)  n_ferr <= n_ferr + 1;
    if (parity_err) n_perr <= n_perr + 1;
    if (overrun)    n_ovr  <= n_ovr + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int bits);
    uart_rxd = b;
    tick(BIT_CLKS * bits);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    drive_bit(1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 1);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d, 1);
`endif
    if (stop_ok) begin
      drive_bit(1'b1, 1);
    end else begin
      drive_bit(1'b0, 2);
      drive_bit(1'b1, 1);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         exp_acc;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int a0, f0, o0, p0;
    int lat;
    logic [7:0] cur;

    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h3C, 1'b0, 0, 1};
    vecs[4] = '{8'h55, 1'b1, 1, 0};
    vecs[5] = '{8'h81, 1'b1, 1, 0};

    rst50    = 1'b1;
    uart_rxd = 1'b1;
    rx_ready = 1'b0;
    tick(5);
    rst50 = 1'b0;
    tick(2);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_busy", busy, 0);
    check("reset_pulses", {frame_err, parity_err, overrun}, 0);

    // Frames with consumer always ready.
    rx_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      a0 = n_acc;
      f0 = n_ferr;
      o0 = n_ovr;
      cur = vecs[v].data;
      send_frame(cur, vecs[v].stop_ok);
      tick(BIT_CLKS);
      check($sformatf("vec%0d_accepts", v), n_acc - a0, vecs[v].exp_acc);
      check($sformatf("vec%0d_frame_err", v), n_ferr - f0, vecs[v].exp_ferr);
      check($sformatf("vec%0d_overrun", v), n_ovr - o0, 0);
      check($sformatf("vec%0d_valid_idle", v), rx_valid, 0);
      if (vecs[v].exp_acc != 0) check($sformatf("vec%0d_data", v), last_acc, cur);
    end
    rx_ready = 1'b0;

    // Short low glitch starts a frame, then is rejected at mid-bit.
    f0 = n_ferr;
    uart_rxd = 1'b0;
    tick(4);
    uart_rxd = 1'b1;
    check("glitch_busy_rise", busy, 1);
    tick(BIT_CLKS);
    check("glitch_busy_fall", busy, 0);
    check("glitch_valid", rx_valid, 0);
    check("glitch_frame_err", n_ferr - f0, 0);

    // Back-to-back frames into a full holding register.
    o0 = n_ovr;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(BIT_CLKS);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_pulse", n_ovr - o0, 1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("ovr_consumed", rx_valid, 0);

    // Measure start-to-deliver latency on an empty register.
    lat = 0;
    fork
      send_frame(8'h77, 1'b1);
      begin
        for (int k = 1; k <= 6000; k++) begin
          tick(1);
          if (rx_valid) begin
            lat = k;
            break;
          end
        end
      end
    join
    check("lat_in_stop_bit", (lat > 9 * BIT_CLKS) && (lat < 10 * BIT_CLKS), 1);
    check("lat_data", rx_data, 8'h77);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("lat_consumed", rx_valid, 0);

    // Consume coinciding with the next deliver keeps rx_valid high.
    send_frame(8'h5A, 1'b1);
    tick(BIT_CLKS);
    check("coin_pending", rx_data, 8'h5A);
    o0 = n_ovr;
    fork
      send_frame(8'h77, 1'b1);
      begin
        tick((lat > 1) ? lat - 1 : 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("coin_valid", rx_valid, 1);
        check("coin_data", rx_data, 8'h77);
      end
    join
    tick(BIT_CLKS);
    check("coin_overrun", n_ovr - o0, 0);
    check("coin_still_valid", rx_valid, 1);

    // Reset during data bit 3 with a byte still pending.
    a0 = n_acc;
    f0 = n_ferr;
    o0 = n_ovr;
    cur = 8'hC3;
    drive_bit(1'b0, 1);
    for (int i = 0; i < 3; i++) drive_bit(cur[i], 1);
    uart_rxd = cur[3];
    tick(BIT_CLKS / 2);
    check("rst_mid_busy_before", busy, 1);
    rst50    = 1'b1;
    uart_rxd = 1'b1;
    tick(1);
    rst50 = 1'b0;
    check("rst_mid_valid", rx_valid, 0);
    check("rst_mid_data", rx_data, 0);
    check("rst_mid_busy", busy, 0);
    tick(3 * BIT_CLKS);
    check("rst_mid_pulses", (n_ferr - f0) + (n_ovr - o0) + (n_acc - a0), 0);
    check("rst_mid_idle", busy, 0);
    send_frame(8'hC3, 1'b1);
    tick(BIT_CLKS);
    check("rst_next_valid", rx_valid, 1);
    check("rst_next_data", rx_data, 8'hC3);

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit: byte dropped with a parity_err pulse.
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    p0  = n_perr;
    cur = 8'h01;
    drive_bit(1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bit(cur[i], 1);
    drive_bit(~(^cur), 1);
    drive_bit(1'b1, 1);
    tick(BIT_CLKS);
    check("par_err_pulse", n_perr - p0, 1);
    check("par_no_valid", rx_valid, 0);
`else
    p0 = n_perr;
    check("par_tied_low", p0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial UART receiver for the noop SoC's uart_rxd input.
- Its counterpart is the noop UART transmitter; on the board the Zynq PS UART drives the line.
- Oversamples the asynchronous rx line, deframes 8N1 characters LSB-first, and presents each byte on a valid/ready holding register for the uncore UART register block.
- Reports framing, parity and overrun errors as single-cycle pulses.

Parameters:
- CLK_FREQ, 50000000: clk50 frequency in Hz.
- BAUD, 115200: line rate in baud.
- OVERSAMPLE, 16: sample ticks per bit. Must be even and >= 8.
- DATA_BITS, 8: data bits per character, range 5..8.

Ports:
- clk50  input  1  sole clock.
- rst50  input  1  synchronous, active-high reset.
- uart_rxd  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_BITS  received byte, LSB = first bit on the wire.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  output  1  1-cycle pulse: stop bit sampled low.
- parity_err  output  1  1-cycle pulse: parity mismatch. Tied 0 when the parity feature is absent.
- overrun  output  1  1-cycle pulse: completed byte dropped because the holding register was full.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst50 sampled high at a clk50 edge):
  - All outputs 0; FSM to IDLE; counters 0.
  - Synchronizer flops preset to 1.
  - Reset mid-frame abandons the partial byte with no error pulse.
- Synchronizer: 2 flops on uart_rxd; all logic uses the second stage (rxs).
- Tick generator:
  - DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE); the default gives 27.
  - Counter runs 0..DIV-1; tick = 1 when the counter equals DIV-1.
  - The counter is cleared on IDLE->START so sampling phase is aligned to the start edge.
- Sample counter: scnt, 0..OVERSAMPLE-1, increments on each tick. The mid-bit point is scnt == OVERSAMPLE/2 - 1.
- Majority vote: bit value = majority of rxs at ticks mid-1, mid and mid+1.
- FSM:
  - IDLE: rxs == 0 -> START, with scnt = 0 and the tick counter cleared.
  - START:
    - At mid-bit, vote 0 -> continue; vote 1 -> IDLE (glitch rejected, no error).
    - On scnt wrap -> DATA, with bit index = 0.
  - DATA:
    - Shift the voted bit into the MSB of the shift register at mid-bit.
    - On wrap: index++; when index == DATA_BITS-1 -> PARITY (feature on) or STOP.
  - PARITY (feature only): voted bit compared at mid-bit; on wrap -> STOP.
  - STOP: at mid-bit:
    - Vote 1 and no parity error -> deliver the byte, then IDLE immediately. There is no wait for the bit end, which allows back-to-back frames.
    - Vote 0 -> frame_err pulse, byte discarded, -> BREAK.
    - Parity error with vote 1 -> parity_err pulse, byte discarded, -> IDLE.
  - BREAK: wait until rxs == 1 -> IDLE. Prevents a held-low line from being taken as repeated starts.
- Deliver (the cycle after the stop mid-bit decision; registered):
  - rx_valid == 0, or rx_ready == 1 in the same cycle: load rx_data, rx_valid = 1.
  - rx_valid == 1 and rx_ready == 0: overrun pulse; new byte dropped, rx_data unchanged.
- Handshake:
  - rx_valid clears the cycle after rx_valid && rx_ready unless a deliver coincides; then it stays 1 with the new data.
  - rx_data is stable while rx_valid is high.
- DATA_BITS < 8: bytes are right-justified. Unused high rx_data bits are not present; the port width is DATA_BITS.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - The PARITY state is inserted between DATA and STOP.
  - Expected bit = XOR of the data bits (even parity).
  - Mismatch -> parity_err pulse; the byte is not delivered.
- Undefined:
  - No PARITY state; frame is 8N1.
  - parity_err is driven constant 0.
  - Port list unchanged.

Decomposition:
- Package uart_pkg:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Function computing DIV from CLK_FREQ / BAUD / OVERSAMPLE.
  - Shared by the future uart_transmitter.
- One sub-module, uart_baud_tick: tick divider with synchronous clear. Reused by the transmitter.
- The FSM, shift register and holding register stay in uart_receiver.

Test Plan:
- Byte at 115200 baud, rx_ready = 1: drive 0xA5 (8N1, bit time 16*27 clocks) -> single rx_valid with rx_data = 0xA5, within 1 clock after the stop-bit mid-sample; no error pulses.
- Glitch rejection: uart_rxd low for 4 clk50 cycles, then high -> busy returns to 0, no rx_valid, no frame_err.
- Framing error: send 0x3C with the stop bit held low for 2 bit times, then release -> one frame_err pulse, no rx_valid; the next frame 0x55 is received correctly.
- Overrun: send 0x11 then 0x22 back-to-back with rx_ready = 0 -> rx_data = 0x11, one overrun pulse. Then assert rx_ready for 1 cycle -> rx_valid = 0.
- Coincident consume: rx_ready pulsed on the exact cycle a second byte 0x77 delivers -> rx_valid stays 1, rx_data = 0x77, no overrun.
- Reset mid-frame: rst50 pulsed during data bit 3 -> all outputs 0, no pulses; the following frame 0xC3 is received correctly. With UART_RX_PARITY_EN, a wrong parity bit on 0x01 -> parity_err pulse, no rx_valid.
